lsu_mem_initiator: RTL

- Memory-stage load/store unit for the pipelined RISC-V core.
- Initiator toward the word-addressed data memory. The memory uses a combinational read, writes on posedge clk when WE=1, and indexes by A>>2.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses. Sub-word stores use a two-cycle read-modify-write.
- Returns sign- or zero-extended load data to writeback.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 59 +++++
 rtl/lsu_mem_initiator.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: data width, RV32I load/store
// funct3 encodings and the two-state read-modify-write state type.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_t;

  // funct3 values that name a real load
  function automatic logic f3_is_load(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3 values that name a real store
  function automatic logic f3_is_store(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte/halfword lane handling for the LSU.
//   LOAD_PATH=1 : o_data = lane of i_word selected by i_addr_lo, extended per
//                 i_funct3 (B/H sign, BU/HU zero, W pass-through).
//   LOAD_PATH=0 : o_data = i_word with the addressed lane replaced by the low
//                 byte/halfword of i_wdata (B/H); W returns i_wdata.
// Ports: i_word (memory word), i_addr_lo (byte offset), i_funct3,
//        i_wdata (store data), o_data (result).
module lsu_lane_align #(
  parameter int XLEN      = 32,
  parameter bit LOAD_PATH = 1'b1
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_addr_lo,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_data
);
  import lsu_pkg::*;

  logic [4:0] w_bit_ofs;
  assign w_bit_ofs = {i_addr_lo, 3'b000};

  generate
    if (LOAD_PATH) begin : g_load
      logic [7:0]  w_byte;
      logic [15:0] w_half;
      logic        w_unused;

      // halfword lane only looks at addr[1]; addr[0] is handled upstream
      assign w_byte   = i_word[w_bit_ofs +: 8];
      assign w_half   = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
      assign w_unused = ^i_wdata;

      always_comb begin
        o_data = i_word;
        case (i_funct3)
          F3_B:    o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
          F3_H:    o_data = {{(XLEN-16){w_half[15]}}, w_half};
          F3_BU:   o_data = {{(XLEN-8){1'b0}}, w_byte};
          F3_HU:   o_data = {{(XLEN-16){1'b0}}, w_half};
          default: o_data = i_word;
        endcase
      end
    end else begin : g_merge
      always_comb begin
        o_data = i_word;
        case (i_funct3)
          F3_B: o_data[w_bit_ofs +: 8] = i_wdata[7:0];
          F3_H: begin
            if (i_addr_lo[1]) o_data[31:16] = i_wdata[15:0];
            else              o_data[15:0]  = i_wdata[15:0];
          end
          default: o_data = i_wdata;
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/lsu_mem_initiator.sv
// Memory-stage load/store unit. Turns RV32I loads/stores into word accesses
// on a combinational-read, posedge-write data memory. SB/SH use a two-cycle
// read-modify-write (read+merge in IDLE, write in RMW_WR).
// Optional: LSU_MISALIGN_EXC_EN flags misaligned H/W accesses on misalign,
//   suppresses such stores and returns 0 for such loads. Undefined: misalign
//   stays 0 and accesses go to the aligned word.
// Ports:
//   clk, rst (sync, active-low)
//   req_valid/req_store/req_funct3/req_addr/req_wdata : request in
//   req_ready : 0 while the RMW write phase stalls the pipe
//   resp_valid/resp_rdata : load result, 1 cycle after acceptance
//   misalign : 1-cycle pulse after a misaligned access (feature build only)
//   mem_addr/mem_wd/mem_we/mem_rd : data memory interface
module lsu_mem_initiator #(
  parameter int XLEN          = 32,
  parameter int ADDR_MASK_LSB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            misalign,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wd,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rd
);
  import lsu_pkg::*;

  lsu_state_t      r_state;
  logic [XLEN-1:0] r_merge;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_rdata;
  logic            r_resp_valid;
  logic            r_misalign;

  logic [XLEN-1:0] w_word_addr;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_merge_data;
  logic            w_acc;
  logic            w_mis;
  logic            w_ld_ok;
  logic            w_st_ok;
  logic            w_do_load;
  logic            w_do_sw;
  logic            w_do_rmw;
  logic            w_mis_evt;

  assign w_word_addr = {req_addr[XLEN-1:ADDR_MASK_LSB], {ADDR_MASK_LSB{1'b0}}};
  assign w_acc       = req_valid && (r_state == IDLE);
  assign w_ld_ok     = f3_is_load(req_funct3);
  assign w_st_ok     = f3_is_store(req_funct3);

`ifdef LSU_MISALIGN_EXC_EN
  assign w_mis = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                 ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  assign w_do_load = w_acc && !req_store && w_ld_ok;
  assign w_do_sw   = w_acc && req_store && (req_funct3 == F3_W) && !w_mis;
  assign w_do_rmw  = w_acc && req_store && w_st_ok && (req_funct3 != F3_W) && !w_mis;
  // only a real (valid funct3) access can raise the flag
  assign w_mis_evt = w_acc && w_mis && (req_store ? w_st_ok : w_ld_ok);

  lsu_lane_align #(.XLEN(XLEN), .LOAD_PATH(1'b1)) u_load_align (
    .i_word    (mem_rd),
    .i_addr_lo (req_addr[1:0]),
    .i_funct3  (req_funct3),
    .i_wdata   (req_wdata),
    .o_data    (w_load_data)
  );

  lsu_lane_align #(.XLEN(XLEN), .LOAD_PATH(1'b0)) u_merge_align (
    .i_word    (mem_rd),
    .i_addr_lo (req_addr[1:0]),
    .i_funct3  (req_funct3),
    .i_wdata   (req_wdata),
    .o_data    (w_merge_data)
  );

  // reset gates the write strobe directly so a pending RMW write is dropped
  assign mem_we     = rst && ((r_state == RMW_WR) || w_do_sw);
  assign mem_addr   = (r_state == RMW_WR) ? r_addr  : w_word_addr;
  assign mem_wd     = (r_state == RMW_WR) ? r_merge : req_wdata;
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign misalign   = r_misalign;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_merge      <= '0;
      r_addr       <= '0;
      r_rdata      <= '0;
      r_resp_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_resp_valid <= w_do_load;
      r_misalign   <= w_mis_evt;
      if (w_do_load) r_rdata <= w_mis ? '0 : w_load_data;
      case (r_state)
        IDLE: begin
          if (w_do_rmw) begin
            r_merge <= w_merge_data;
            r_addr  <= w_word_addr;
            r_state <= RMW_WR;
          end
        end
        RMW_WR:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
